// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch-to-decode and decode-to-execute handshake bundle
interface decode_if #(
    parameter int PC_W = 20
) ();
    logic [15:0]     in_word;
    logic [PC_W-1:0] in_pc;
    logic            in_valid;
    logic            in_ready;

    logic            out_valid;
    logic            out_ready;
    logic            out_is32;
    logic [31:0]     out_word;
    logic [PC_W-1:0] out_pc;
    logic [3:0]      out_class;
    logic [7:0]      out_opcode;
    logic [5:0]      out_dest;
    logic [5:0]      out_srca;
    logic [5:0]      out_srcb;

    modport slave (
        input  in_word, in_pc, in_valid, out_ready,
        output in_ready, out_valid, out_is32, out_word, out_pc,
        output out_class, out_opcode, out_dest, out_srca, out_srcb
    );

    modport master (
        output in_word, in_pc, in_valid, out_ready,
        input  in_ready, out_valid, out_is32, out_word, out_pc,
        input  out_class, out_opcode, out_dest, out_srca, out_srcb
    );
endinterface

// File: rtl/decode.sv
// rtl/decode.sv - instruction decode stage assembling 16/32-bit instructions
module decode #(
    parameter int PC_W = 20,
    parameter int IW   = 16
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   flush,
    decode_if.slave bus
);

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]   hold_word;
    logic [PC_W-1:0] hold_pc;

    logic            valid_q;
    logic            is32_q;
    logic [2*IW-1:0] word_q;
    logic [PC_W-1:0] pc_q;
    logic [3:0]      class_q;
    logic [7:0]      opcode_q;
    logic [5:0]      dest_q;
    logic [5:0]      srca_q;
    logic [5:0]      srcb_q;

    logic            ready;
    logic            accept;
    logic            load;
    logic            load_is32;
    logic            latch_first;
    logic [IW-1:0]   lo_word;
    logic [IW-1:0]   hi_word;
    logic [PC_W-1:0] load_pc;

    assign ready  = ~valid_q | bus.out_ready;
    assign accept = bus.in_valid & ready;

    // A 16-bit instruction is treated as a 32-bit one with an all-zero high
    // half, so one field concatenation yields both zero-extension and pairing.
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        load_is32   = 1'b0;
        latch_first = 1'b0;
        lo_word     = bus.in_word;
        hi_word     = '0;
        load_pc     = bus.in_pc;
        if (state == SECOND) begin
            lo_word = hold_word;
            hi_word = bus.in_word;
            load_pc = hold_pc;
        end
        if (flush) begin
            state_next = FIRST;
        end else if (accept) begin
            case (state)
                FIRST: begin
                    if (bus.in_word[15]) begin
                        latch_first = 1'b1;
                        state_next  = SECOND;
                    end else begin
                        load = 1'b1;
                    end
                end
                SECOND: begin
                    load       = 1'b1;
                    load_is32  = 1'b1;
                    state_next = FIRST;
                end
                default: state_next = FIRST;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FIRST;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            hold_word <= '0;
            hold_pc   <= '0;
        end else if (latch_first) begin
            hold_word <= bus.in_word;
            hold_pc   <= bus.in_pc;
        end
    end

    // Flush outranks both a new load and out_ready; data is left as-is since
    // it is don't-care once out_valid drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            is32_q   <= 1'b0;
            word_q   <= '0;
            pc_q     <= '0;
            class_q  <= '0;
            opcode_q <= '0;
            dest_q   <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q  <= 1'b1;
            is32_q   <= load_is32;
            word_q   <= {hi_word, lo_word};
            pc_q     <= load_pc;
            class_q  <= {hi_word[14:13], lo_word[14:13]};
            opcode_q <= {hi_word[12:9],  lo_word[12:9]};
            dest_q   <= {hi_word[8:6],   lo_word[8:6]};
            srca_q   <= {hi_word[5:3],   lo_word[5:3]};
            srcb_q   <= {hi_word[2:0],   lo_word[2:0]};
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_is32   = is32_q;
    assign bus.out_word   = word_q;
    assign bus.out_pc     = pc_q;
    assign bus.out_class  = class_q;
    assign bus.out_opcode = opcode_q;
    assign bus.out_dest   = dest_q;
    assign bus.out_srca   = srca_q;
    assign bus.out_srcb   = srcb_q;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed self-checking bench for decode
module tb_decode;

    localparam int PC_W = 20;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    decode_if #(.PC_W(PC_W)) bus ();

    decode #(.PC_W(PC_W), .IW(16)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] w, input logic [PC_W-1:0] pc, input logic v);
        bus.in_word  = w;
        bus.in_pc    = pc;
        bus.in_valid = v;
    endtask

    task automatic expect_out(input string tag, input logic is32, input logic [31:0] w,
                              input logic [PC_W-1:0] pc, input logic [3:0] cls,
                              input logic [7:0] op, input logic [5:0] d,
                              input logic [5:0] a, input logic [5:0] b);
        expect_eq({tag, ".valid"},  bus.out_valid,  1'b1);
        expect_eq({tag, ".is32"},   bus.out_is32,   is32);
        expect_eq({tag, ".word"},   bus.out_word,   w);
        expect_eq({tag, ".pc"},     bus.out_pc,     pc);
        expect_eq({tag, ".class"},  bus.out_class,  cls);
        expect_eq({tag, ".opcode"}, bus.out_opcode, op);
        expect_eq({tag, ".dest"},   bus.out_dest,   d);
        expect_eq({tag, ".srca"},   bus.out_srca,   a);
        expect_eq({tag, ".srcb"},   bus.out_srcb,   b);
    endtask

    task automatic expect_zero(input string tag);
        expect_eq({tag, ".valid"}, bus.out_valid, 1'b0);
        expect_eq({tag, ".is32"},  bus.out_is32,  1'b0);
        expect_eq({tag, ".word"},  bus.out_word,  32'h0);
        expect_eq({tag, ".pc"},    bus.out_pc,    20'h0);
        expect_eq({tag, ".flds"},
                  {bus.out_class, bus.out_opcode, bus.out_dest, bus.out_srca, bus.out_srcb}, 64'h0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(16'h0, 20'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        expect_zero("rst");
        expect_eq("rst.in_ready", bus.in_ready, 1'b1);

        // 16-bit instruction, one-cycle latency
        drive(16'h1234, 20'h00010, 1'b1);
        tick();
        drive(16'h0, 20'h0, 1'b0);
        expect_out("i16", 1'b0, 32'h0000_1234, 20'h00010, 4'd0, 8'd9, 6'd0, 6'd6, 6'd4);

        // 32-bit instruction assembled from two words
        drive(16'h8A53, 20'h00020, 1'b1);
        tick();
        expect_eq("i32.half.valid", bus.out_valid, 1'b0);
        drive(16'h0249, 20'h00021, 1'b1);
        tick();
        drive(16'h0, 20'h0, 1'b0);
        expect_out("i32", 1'b1, 32'h0249_8A53, 20'h00020, 4'd0, 8'h15, 6'd9, 6'd10, 6'd11);
        tick();
        expect_eq("i32.drain.valid", bus.out_valid, 1'b0);

        // Backpressure: held output stays stable, then no-bubble replacement
        bus.out_ready = 1'b0;
        drive(16'h1234, 20'h00030, 1'b1);
        tick();
        drive(16'h0005, 20'h00031, 1'b1);
        #1;
        expect_eq("bp.in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_eq("bp.hold.valid", bus.out_valid, 1'b1);
            expect_eq("bp.hold.word",  bus.out_word,  32'h0000_1234);
            expect_eq("bp.hold.pc",    bus.out_pc,    20'h00030);
        end
        bus.out_ready = 1'b1;
        #1;
        expect_eq("bp.release.in_ready", bus.in_ready, 1'b1);
        tick();
        drive(16'h0, 20'h0, 1'b0);
        expect_out("bp.next", 1'b0, 32'h0000_0005, 20'h00031, 4'd0, 8'd0, 6'd0, 6'd0, 6'd5);
        tick();
        expect_eq("bp.drain.valid", bus.out_valid, 1'b0);

        // Flush mid-assembly drops the half and the word accepted alongside
        drive(16'h8A53, 20'h00040, 1'b1);
        tick();
        drive(16'h0249, 20'h00041, 1'b1);
        flush = 1'b1;
        #1;
        expect_eq("fl.in_ready", bus.in_ready, 1'b1);
        tick();
        flush = 1'b0;
        expect_eq("fl.valid", bus.out_valid, 1'b0);
        drive(16'h1234, 20'h00042, 1'b1);
        tick();
        drive(16'h0, 20'h0, 1'b0);
        bus.out_ready = 1'b0;
        expect_out("fl.after", 1'b0, 32'h0000_1234, 20'h00042, 4'd0, 8'd9, 6'd0, 6'd6, 6'd4);

        // Reset while an instruction is held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_zero("rmid");
        bus.out_ready = 1'b1;

        // Reset during assembly discards the first half
        drive(16'h8A53, 20'h00050, 1'b1);
        tick();
        drive(16'h0, 20'h0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(16'h1234, 20'h00055, 1'b1);
        tick();
        drive(16'h0, 20'h0, 1'b0);
        expect_out("rhalf", 1'b0, 32'h0000_1234, 20'h00055, 4'd0, 8'd9, 6'd0, 6'd6, 6'd4);

        // Streaming mix; second half has bit 15 set, which must be ignored
        drive(16'h1234, 20'h00060, 1'b1);
        tick();
        expect_out("s0", 1'b0, 32'h0000_1234, 20'h00060, 4'd0, 8'd9, 6'd0, 6'd6, 6'd4);
        drive(16'h8A53, 20'h00061, 1'b1);
        tick();
        expect_eq("s1.half.valid", bus.out_valid, 1'b0);
        drive(16'h8249, 20'h00062, 1'b1);
        tick();
        expect_out("s1", 1'b1, 32'h8249_8A53, 20'h00061, 4'd0, 8'h15, 6'd9, 6'd10, 6'd11);
        drive(16'h7FFF, 20'h00063, 1'b1);
        tick();
        expect_out("s2", 1'b0, 32'h0000_7FFF, 20'h00063, 4'd3, 8'd15, 6'd7, 6'd7, 6'd7);
        drive(16'h0, 20'h0, 1'b0);
        tick();
        expect_eq("s.drain.valid", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
